// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the UART ALU packet engine: opcode values, the
// header/response framing sizes and the engine FSM state type.
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA0;
    localparam logic [7:0] OP_MUL32 = 8'hA1;

    localparam int HDR_BYTES  = 4;
    localparam int RESP_BYTES = 4;

    typedef enum logic [2:0] {
        S_HDR,
        S_ECHO,
        S_OPND,
        S_RESP,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/alu_packet_engine.sv
// ----------------------------------------------------------------------------
// alu_packet_engine
// Command responder sitting between uart_rx (AXIS master) and uart_tx (AXIS
// slave). Parses [opcode, rsvd, len_lo, len_hi, payload...] packets, where len
// counts the whole packet including the 4-byte header, and runs ECHO, ADD32
// or MUL32, streaming the response bytes back out.
//
// Ports
//   clk_12mhz_i     system clock
//   reset_unsafe_i  synchronous, active-high reset
//   s_axis_*        rx byte stream from uart_rx (tdata/tvalid in, tready out)
//   m_axis_*        tx byte stream to uart_tx (tdata/tvalid out, tready in)
//   busy_o          high whenever the engine is not waiting for a header
//   error_o         one-cycle pulse when a packet is rejected
// ----------------------------------------------------------------------------
module alu_packet_engine
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_12mhz_i,
    input  logic                  reset_unsafe_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  error_o
);

    state_t      state;
    logic [1:0]  hdr_idx;
    logic [7:0]  op;
    logic [7:0]  len_lo;
    logic [15:0] remaining;
    logic [1:0]  byte_idx;
    logic        first_word;
    logic [23:0] word_lo;      // operand bytes 0..2; byte 3 arrives live
    logic [31:0] acc;
    logic [1:0]  resp_idx;

    logic        s_fire;
    logic        m_fire;
    logic [15:0] len_full;
    logic [15:0] rem_hdr;
    logic        is_arith;
    logic [31:0] word_full;
    logic [31:0] acc_next;

    assign s_fire    = s_axis_tvalid & s_axis_tready;
    assign m_fire    = m_axis_tvalid & m_axis_tready;
    assign len_full  = {s_axis_tdata, len_lo};
    assign rem_hdr   = len_full - 16'(HDR_BYTES);
    assign is_arith  = (op == OP_ADD32) || (op == OP_MUL32);
    assign word_full = {s_axis_tdata, word_lo};
    assign busy_o    = (state != S_HDR);

    // Modulo-2^32 unsigned: the 32-bit target keeps only the low product bits.
    always_comb begin
        acc_next = word_full;
        if (!first_word) begin
            acc_next = (op == OP_ADD32) ? acc + word_full : acc * word_full;
        end
    end

    // Handshake outputs are combinational on state so ECHO can pass bytes
    // through with zero latency. Reset gates them so both streams are idle
    // while reset is held.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        if (!reset_unsafe_i) begin
            case (state)
                S_HDR, S_OPND, S_DRAIN: s_axis_tready = 1'b1;
                S_ECHO: begin
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                end
                S_RESP: begin
                    m_axis_tvalid = 1'b1;
                    case (resp_idx)
                        2'd0:    m_axis_tdata = acc[7:0];
                        2'd1:    m_axis_tdata = acc[15:8];
                        2'd2:    m_axis_tdata = acc[23:16];
                        default: m_axis_tdata = acc[31:24];
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_12mhz_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_unsafe_i) begin
            state      <= S_HDR;
            hdr_idx    <= '0;
            op         <= '0;
            len_lo     <= '0;
            remaining  <= '0;
            byte_idx   <= '0;
            first_word <= 1'b0;
            word_lo    <= '0;
            acc        <= '0;
            resp_idx   <= '0;
            error_o    <= 1'b0;
        end else begin
            error_o <= 1'b0;
            case (state)
                S_HDR: begin
                    if (s_fire) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0: op     <= s_axis_tdata;
                            2'd2: len_lo <= s_axis_tdata;
                            2'd3: begin
                                remaining <= rem_hdr;
                                if (op == OP_ECHO && len_full >= 16'(HDR_BYTES)) begin
                                    // A bare header echoes nothing.
                                    if (rem_hdr != '0) state <= S_ECHO;
                                end else if (is_arith && len_full >= 16'(HDR_BYTES + 4)
                                             && len_full[1:0] == 2'b00) begin
                                    state      <= S_OPND;
                                    first_word <= 1'b1;
                                    byte_idx   <= '0;
                                end else begin
                                    error_o <= 1'b1;
                                    if (rem_hdr != '0) state <= S_DRAIN;
                                end
                            end
                            default: ;   // reserved byte is ignored
                        endcase
                    end
                end
                S_ECHO: begin
                    if (s_fire) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= S_HDR;
                    end
                end
                S_OPND: begin
                    if (s_fire) begin
                        remaining <= remaining - 16'd1;
                        byte_idx  <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_lo[7:0]   <= s_axis_tdata;
                            2'd1: word_lo[15:8]  <= s_axis_tdata;
                            2'd2: word_lo[23:16] <= s_axis_tdata;
                            default: begin
                                acc        <= acc_next;
                                first_word <= 1'b0;
                            end
                        endcase
                        // len is a multiple of 4, so this coincides with a word boundary.
                        if (remaining == 16'd1) begin
                            state    <= S_RESP;
                            resp_idx <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (m_fire) begin
                        resp_idx <= resp_idx + 2'd1;
                        if (resp_idx == 2'(RESP_BYTES - 1)) state <= S_HDR;
                    end
                end
                S_DRAIN: begin
                    if (s_fire) begin
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) state <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end

endmodule
